interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 131 +++++++++++++
 tb/tb_interrupt_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - single-level vectored interrupt controller, lowest index wins
// Optional macro IRQ_EDGE_DETECT_EN: rising-edge pending capture instead of level sampling.
module interrupt_controller #(
    parameter int NIRQ       = 8,
    parameter int VEC_STRIDE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NIRQ-1:0]         irq,
    input  logic                    mask_we,
    input  logic [NIRQ-1:0]         mask_wdata,
    input  logic [31:0]             isr_base,
    input  logic [31:0]             pcnext,
    input  logic                    add_stall,
    input  logic                    reti,
    output logic                    interrupt,
    output logic [31:0]             pc_isr,
    output logic [31:0]             epc,
    output logic [$clog2(NIRQ)-1:0] irq_id,
    output logic                    in_service,
    output logic [NIRQ-1:0]         pending
);
    localparam int IDW = $clog2(NIRQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q;
    logic [NIRQ-1:0] eligible;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    logic [IDW-1:0]  sel_idx;
    logic [31:0]     epc_q;
    logic            take;

    assign eligible = pending_q & mask_q;

    // Descending scan so the lowest eligible index is the last writer.
    always_comb begin
        sel_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_idx = IDW'(i);
            end
        end
    end

    // Gated by rst so an abandoned ISSUE never pulses during the reset cycle.
    assign take = (state_q == ISSUE) && !add_stall && !rst;

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = ISSUE;
                    irq_id_d = sel_idx;
                end
            end
            ISSUE: begin
                if (!add_stall) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NIRQ-1:0] irq_prev_q;
    logic [NIRQ-1:0] clr;

    always_comb begin
        clr = '0;
        if (take) begin
            clr[irq_id_q] = 1'b1;
        end
    end

    // A fresh edge on the line being accepted survives the clear.
    assign pending_d = (pending_q & ~clr) | (irq & ~irq_prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq;
        end
    end
`else
    assign pending_d = irq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_id_q  <= '0;
            epc_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            if (take) begin
                epc_q <= pcnext;
            end
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign interrupt  = take;
    assign pc_isr     = isr_base + (32'(irq_id_q) * 32'(VEC_STRIDE));
    assign epc        = epc_q;
    assign irq_id     = irq_id_q;
    assign in_service = (state_q == SERVICE);
    assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized and directed checks of interrupt_controller against a behavioural model
module tb_interrupt_controller;
    localparam int NIRQ   = 8;
    localparam int STRIDE = 4;
    localparam int IDW    = $clog2(NIRQ);
    localparam int P_IDLE = 0;
    localparam int P_ISSUE = 1;
    localparam int P_SERV = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIRQ-1:0] irq;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic [31:0]     isr_base;
    logic [31:0]     pcnext;
    logic            add_stall;
    logic            reti;
    logic            interrupt;
    logic [31:0]     pc_isr;
    logic [31:0]     epc;
    logic [IDW-1:0]  irq_id;
    logic            in_service;
    logic [NIRQ-1:0] pending;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    int              m_phase = P_IDLE;
    int              m_id    = 0;
    logic [NIRQ-1:0] m_pend  = '0;
    logic [NIRQ-1:0] m_mask  = '0;
    logic [NIRQ-1:0] m_prev  = '0;
    logic [31:0]     m_epc   = '0;

    interrupt_controller #(.NIRQ(NIRQ), .VEC_STRIDE(STRIDE)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .isr_base(isr_base), .pcnext(pcnext), .add_stall(add_stall), .reti(reti),
        .interrupt(interrupt), .pc_isr(pc_isr), .epc(epc), .irq_id(irq_id),
        .in_service(in_service), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: one pending set, one mask, one interrupt in flight at most.
    always @(posedge clk) begin : model
        logic [NIRQ-1:0] elig;
        logic [NIRQ-1:0] clr;
        logic [NIRQ-1:0] pend_n;
        bit              accept;
        int              phase_n;
        int              id_n;
        accept = (m_phase == P_ISSUE) && !add_stall && !rst;
        if (rst) begin
            m_phase <= P_IDLE;
            m_id    <= 0;
            m_pend  <= '0;
            m_mask  <= '0;
            m_prev  <= '0;
            m_epc   <= '0;
        end else begin
            elig    = m_pend & m_mask;
            phase_n = m_phase;
            id_n    = m_id;
            clr     = '0;
            if (accept) clr[m_id] = 1'b1;
`ifdef IRQ_EDGE_DETECT_EN
            pend_n = (m_pend & ~clr) | (irq & ~m_prev);
`else
            pend_n = irq;
`endif
            if (m_phase == P_IDLE && elig != '0) begin
                id_n = 0;
                while (!elig[id_n]) id_n++;
                phase_n = P_ISSUE;
            end else if (accept) begin
                phase_n = P_SERV;
            end else if (m_phase == P_SERV && reti) begin
                phase_n = P_IDLE;
            end
            m_phase <= phase_n;
            m_id    <= id_n;
            m_pend  <= pend_n;
            m_prev  <= irq;
            if (accept) m_epc <= pcnext;
            if (mask_we) m_mask <= mask_wdata;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] exp_pc;
        if (chk_en) begin
            exp_pc = isr_base + 32'(m_id) * 32'(STRIDE);
            chk("interrupt", 32'(interrupt), 32'((m_phase == P_ISSUE) && !add_stall && !rst));
            chk("in_service", 32'(in_service), 32'(m_phase == P_SERV));
            chk("irq_id", 32'(irq_id), 32'(m_id));
            chk("epc", epc, m_epc);
            chk("pending", 32'(pending), 32'(m_pend));
            if (m_phase == P_ISSUE) chk("pc_isr", pc_isr, exp_pc);
        end
    end

    initial begin
        rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; isr_base = '0;
        pcnext = '0; add_stall = 1'b0; reti = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #2;
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // Single pulse on line 0
        mask_we = 1'b1; mask_wdata = 8'h01; isr_base = 32'h100; pcnext = 32'h20;
        tick();
        mask_we = 1'b0; irq = 8'h01;
        tick();
        irq = '0;
        #2; chk("pulse_c1_interrupt", 32'(interrupt), 32'd0);
        tick();
        #2; chk("pulse_c2_interrupt", 32'(interrupt), 32'd1);
        chk("pulse_c2_pc_isr", pc_isr, 32'h100);
        tick();
        #2; chk("pulse_epc", epc, 32'h20);
        chk("pulse_in_service", 32'(in_service), 32'd1);
        reti = 1'b1; tick(); reti = 1'b0; tick();

        // Simultaneous lines 5 and 2
        mask_we = 1'b1; mask_wdata = 8'hFF; isr_base = 32'h2000;
        tick();
        mask_we = 1'b0; irq = 8'h24;
        tick();
        tick();
        #2; chk("prio_irq_id", 32'(irq_id), 32'd2);
        chk("prio_pc_isr", pc_isr, 32'h2008);
        chk("prio_interrupt", 32'(interrupt), 32'd1);
        tick();
        irq = 8'h20; reti = 1'b1;
        tick();
        reti = 1'b0;
        #2; chk("prio_returned", 32'(in_service), 32'd0);
        tick();
        #2; chk("second_irq_id", 32'(irq_id), 32'd5);
        chk("second_pc_isr", pc_isr, 32'h2014);
        chk("second_interrupt", 32'(interrupt), 32'd1);
        tick();
        irq = '0; reti = 1'b1; tick(); reti = 1'b0; tick();

        // Stall held for three ISSUE cycles
        pcnext = 32'h40; irq = 8'h02;
        tick();
        irq = '0; add_stall = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #2; chk("stall_interrupt", 32'(interrupt), 32'd0);
            tick();
        end
        add_stall = 1'b0; pcnext = 32'h44;
        #2; chk("unstall_interrupt", 32'(interrupt), 32'd1);
        chk("unstall_pc_isr", pc_isr, 32'h2004);
        tick();
        #2; chk("unstall_epc", epc, 32'h44);
        chk("unstall_in_service", 32'(in_service), 32'd1);
        reti = 1'b1; tick(); reti = 1'b0; tick();

        // Masked request stays pending until unmasked
        mask_we = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0; irq = 8'h08;
        tick(); tick(); tick();
        #2; chk("masked_pending3", 32'(pending[3]), 32'd1);
        chk("masked_interrupt", 32'(interrupt), 32'd0);
        mask_we = 1'b1; mask_wdata = 8'h08;
        tick();
        mask_we = 1'b0;
        tick();
        #2; chk("unmask_interrupt", 32'(interrupt), 32'd1);
        chk("unmask_irq_id", 32'(irq_id), 32'd3);
        tick();
        irq = '0; reti = 1'b1; tick(); reti = 1'b0; tick();

        // Vector address wraps past 2^32
        isr_base = 32'hFFFF_FFFC; mask_we = 1'b1; mask_wdata = 8'h02;
        tick();
        mask_we = 1'b0; irq = 8'h02;
        tick(); tick();
        #2; chk("wrap_irq_id", 32'(irq_id), 32'd1);
        chk("wrap_pc_isr", pc_isr, 32'h0000_0000);
        chk("wrap_interrupt", 32'(interrupt), 32'd1);
        tick();
        irq = '0; reti = 1'b1; tick(); reti = 1'b0; tick();

        // Reset while servicing
        mask_we = 1'b1; mask_wdata = 8'h01;
        tick();
        mask_we = 1'b0; irq = 8'h01;
        tick(); tick(); tick();
        #2; chk("svc_in_service", 32'(in_service), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2; chk("svcrst_in_service", 32'(in_service), 32'd0);
        chk("svcrst_pending", 32'(pending), 32'd0);
        chk("svcrst_interrupt", 32'(interrupt), 32'd0);
        tick(); tick(); tick();
        #2; chk("svcrst_still_idle", 32'(interrupt), 32'd0);
        chk("svcrst_no_service", 32'(in_service), 32'd0);
        irq = '0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < NIRQ; b++) begin
                if ($urandom_range(7) == 0) irq[b] = ~irq[b];
            end
            mask_we    = ($urandom_range(9) == 0);
            mask_wdata = NIRQ'($urandom);
            add_stall  = ($urandom_range(2) == 0);
            reti       = ($urandom_range(3) == 0);
            rst        = ($urandom_range(149) == 0);
            pcnext     = $urandom;
            if ($urandom_range(63) == 0) isr_base = $urandom;
            tick();
        end
        rst = 1'b0; irq = '0; mask_we = 1'b0; add_stall = 1'b0; reti = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
